// File: rtl/kronos_hcu_sb_if.sv
// Decode/write-back side signals of the scoreboard hazard control unit.
// The master is the pipeline (decode + write-back); the slave is the HCU.
interface kronos_hcu_sb_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic [31:0]   instr;
  logic          regrd_rs1_en;
  logic          regrd_rs2_en;
  logic          decode_vld;
  logic          decode_rdy;
  logic [4:0]    regwr_sel;
  logic          regwr_en;
  logic          stall;
  logic          full;
  logic [CW-1:0] count;
  logic          retire_err;

  modport master (
    output flush, instr, regrd_rs1_en, regrd_rs2_en, decode_vld, decode_rdy,
           regwr_sel, regwr_en,
    input  stall, full, count, retire_err
  );

  modport slave (
    input  flush, instr, regrd_rs1_en, regrd_rs2_en, decode_vld, decode_rdy,
           regwr_sel, regwr_en,
    output stall, full, count, retire_err
  );
endinterface

// File: rtl/kronos_hcu_sb.sv
// Scoreboard hazard control unit. Tracks up to DEPTH in-flight register writes
// in issue order and stalls decode while an operand has an older uncommitted
// write, or while the scoreboard is full. Write-backs retire strictly in order;
// an operand is released in the cycle its write-back lands (write-through regfile).
module kronos_hcu_sb #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rstz,
  kronos_hcu_sb_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_OPIMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_OP    = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_SYS   = 5'b11100;

  logic [4:0]    r_rd [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [4:0]    w_op;
  logic [4:0]    w_rd;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [2:0]    w_f3;
  logic          w_is_wr;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_err;
  logic          w_hz_rs1;
  logic          w_hz_rs2;
  logic          w_struct;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;
  logic          w_unused;

  // Funct7, immediate high bits and the length bits play no part in hazards.
  assign w_unused = ^{bus.instr[31:25], bus.instr[1:0]};

  assign w_op  = bus.instr[6:2];
  assign w_rd  = bus.instr[11:7];
  assign w_f3  = bus.instr[14:12];
  assign w_rs1 = bus.instr[19:15];
  assign w_rs2 = bus.instr[24:20];

  // Classify the decode-stage instruction as a register writer.
  always_comb begin
    w_is_wr = 1'b0;
    case (w_op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP, OP_LOAD: w_is_wr = 1'b1;
      OP_SYS:  w_is_wr = (w_f3 != 3'd0) && (w_f3 != 3'd4);
      default: w_is_wr = 1'b0;
    endcase
    if (w_rd == 5'd0) w_is_wr = 1'b0;
  end

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = bus.regwr_en && !w_empty;
  assign w_push_req = bus.decode_vld && bus.decode_rdy && w_is_wr;
  // When full, a same-cycle retire frees the head slot, which is the tail slot.
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
  assign w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);

  assign w_err = !bus.flush &&
                 ((bus.regwr_en && w_empty) ||
                  (w_pop && (bus.regwr_sel != r_rd[r_head])) ||
                  (w_push_req && w_full && !w_pop));

  // Operand hazards: any valid entry matching the operand, except the head entry
  // when it is retiring this cycle. A younger duplicate keeps the hazard alive.
  always_comb begin
    w_hz_rs1 = 1'b0;
    w_hz_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] == w_rs1) &&
          !((r_head == PW'(i)) && w_pop && (bus.regwr_sel == w_rs1)))
        w_hz_rs1 = 1'b1;
      if (r_vld[i] && (r_rd[i] == w_rs2) &&
          !((r_head == PW'(i)) && w_pop && (bus.regwr_sel == w_rs2)))
        w_hz_rs2 = 1'b1;
    end
    w_hz_rs1 = w_hz_rs1 && bus.regrd_rs1_en && (w_rs1 != 5'd0);
    w_hz_rs2 = w_hz_rs2 && bus.regrd_rs2_en && (w_rs2 != 5'd0);
  end

  assign w_struct = bus.decode_vld && w_is_wr && w_full && !bus.regwr_en;

  assign bus.stall      = (bus.decode_vld && (w_hz_rs1 || w_hz_rs2)) || w_struct;
  assign bus.full       = w_full;
  assign bus.count      = r_count;
  assign bus.retire_err = r_err;

  // Scoreboard FIFO: retire at head, allocate at tail; flush discards everything.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_rd[i] <= 5'd0;
    end else begin
      r_err <= w_err;
      if (bus.flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_vld   <= '0;
      end else begin
        if (w_pop) begin
          r_vld[r_head] <= 1'b0;
          r_head        <= w_head_nxt;
        end
        // Allocation after retire so a full push+pop leaves the shared slot valid.
        if (w_push) begin
          r_rd[r_tail]  <= w_rd;
          r_vld[r_tail] <= 1'b1;
          r_tail        <= w_tail_nxt;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kronos_hcu_sb.sv
// Directed bench for kronos_hcu_sb: a DEPTH=2 instance for the hazard,
// full, flush and error cases, and a DEPTH=3 instance for pointer wrap.
module tb_kronos_hcu_sb;

  logic clk = 1'b0;
  logic rstz;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  kronos_hcu_sb_if #(.DEPTH(2)) bus2 ();
  kronos_hcu_sb_if #(.DEPTH(3)) bus3 ();

  kronos_hcu_sb #(.DEPTH(2)) u_dut2 (.clk(clk), .rstz(rstz), .bus(bus2));
  kronos_hcu_sb #(.DEPTH(3)) u_dut3 (.clk(clk), .rstz(rstz), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] f_csrrw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h300, rs1, 3'b001, rd, 7'b1110011};
  endfunction

  task automatic d2(input logic vld, input logic rdy, input logic [31:0] ins,
                    input logic e1, input logic e2, input logic we,
                    input logic [4:0] ws, input logic fl);
    bus2.decode_vld   = vld;
    bus2.decode_rdy   = rdy;
    bus2.instr        = ins;
    bus2.regrd_rs1_en = e1;
    bus2.regrd_rs2_en = e2;
    bus2.regwr_en     = we;
    bus2.regwr_sel    = ws;
    bus2.flush        = fl;
  endtask

  task automatic d3(input logic vld, input logic rdy, input logic [31:0] ins,
                    input logic e1, input logic e2, input logic we,
                    input logic [4:0] ws, input logic fl);
    bus3.decode_vld   = vld;
    bus3.decode_rdy   = rdy;
    bus3.instr        = ins;
    bus3.regrd_rs1_en = e1;
    bus3.regrd_rs2_en = e2;
    bus3.regwr_en     = we;
    bus3.regwr_sel    = ws;
    bus3.flush        = fl;
  endtask

  initial begin
    rstz = 1'b0;
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);
    d3(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 32'(bus2.count), 0);
    check("rst_full", 32'(bus2.full), 0);
    check("rst_err", 32'(bus2.retire_err), 0);
    check("rst_stall", 32'(bus2.stall), 0);
    @(negedge clk);
    rstz = 1'b1;

    // 1: writer x5, then dependent ADD x6,x5,x1 held until x5 commits
    @(negedge clk);
    d2(1, 1, f_addi(5'd5, 5'd1), 1, 0, 0, 5'd0, 0);
    #1 check("t1_first_nostall", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t1_cnt1", 32'(bus2.count), 1);
    d2(1, 0, f_add(5'd6, 5'd5, 5'd1), 1, 1, 0, 5'd0, 0);
    #1 check("t1_stall_a", 32'(bus2.stall), 1);
    @(negedge clk);
    d2(1, 0, f_add(5'd6, 5'd5, 5'd1), 1, 1, 0, 5'd0, 0);
    #1 check("t1_stall_b", 32'(bus2.stall), 1);
    @(negedge clk);
    d2(1, 0, f_add(5'd6, 5'd5, 5'd1), 1, 1, 1, 5'd5, 0);
    #1 check("t1_release", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t1_cnt0", 32'(bus2.count), 0);
    check("t1_err", 32'(bus2.retire_err), 0);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);

    // 2: fill with x3,x4; third writer x7 waits for a retire, then goes in with it
    @(negedge clk);
    d2(1, 1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 1, f_addi(5'd4, 5'd0), 1, 0, 0, 5'd0, 0);
    #1 check("t2_second_nostall", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t2_cnt2", 32'(bus2.count), 2);
    check("t2_full", 32'(bus2.full), 1);
    d2(1, 0, f_addi(5'd7, 5'd0), 1, 0, 0, 5'd0, 0);
    #1 check("t2_struct_stall", 32'(bus2.stall), 1);
    @(negedge clk);
    d2(1, 1, f_addi(5'd7, 5'd0), 1, 0, 1, 5'd3, 0);
    #1 check("t2_struct_release", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t2_cnt_keep", 32'(bus2.count), 2);
    check("t2_full_keep", 32'(bus2.full), 1);
    check("t2_err", 32'(bus2.retire_err), 0);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd4, 0);
    @(negedge clk);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd7, 0);
    @(negedge clk);
    check("t2_drain_cnt", 32'(bus2.count), 0);
    check("t2_drain_err", 32'(bus2.retire_err), 0);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);

    // 3: two writers of x5; reader stays blocked until the younger one commits
    @(negedge clk);
    d2(1, 1, f_addi(5'd5, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 1, f_addi(5'd5, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 0, f_beq(5'd5, 5'd0), 1, 1, 0, 5'd0, 0);
    #1 check("t3_stall", 32'(bus2.stall), 1);
    @(negedge clk);
    d2(1, 0, f_beq(5'd5, 5'd0), 1, 1, 1, 5'd5, 0);
    #1 check("t3_dup_keeps", 32'(bus2.stall), 1);
    @(negedge clk);
    check("t3_cnt1", 32'(bus2.count), 1);
    d2(1, 0, f_beq(5'd5, 5'd0), 1, 1, 1, 5'd5, 0);
    #1 check("t3_release", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t3_cnt0", 32'(bus2.count), 0);
    check("t3_err", 32'(bus2.retire_err), 0);

    // 4: x0 writer/reader and ECALL never allocate; CSRRW with rd!=0 does
    d2(1, 1, f_addi(5'd0, 5'd0), 1, 0, 0, 5'd0, 0);
    #1 check("t4_x0_wr_nostall", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t4_x0_nopush", 32'(bus2.count), 0);
    d2(1, 1, f_beq(5'd0, 5'd0), 1, 1, 0, 5'd0, 0);
    #1 check("t4_x0_rd_nostall", 32'(bus2.stall), 0);
    @(negedge clk);
    d2(1, 1, 32'h0000_0073, 0, 0, 0, 5'd0, 0);
    @(negedge clk);
    check("t4_ecall_nopush", 32'(bus2.count), 0);
    d2(1, 1, f_csrrw(5'd8, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    check("t4_csr_push", 32'(bus2.count), 1);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd8, 0);
    @(negedge clk);
    check("t4_csr_retire", 32'(bus2.count), 0);
    check("t4_err", 32'(bus2.retire_err), 0);

    // 5: flush with a concurrent write-back clears everything silently
    d2(1, 1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 1, f_addi(5'd4, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    check("t5_cnt2", 32'(bus2.count), 2);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd3, 1);
    @(negedge clk);
    check("t5_flush_cnt", 32'(bus2.count), 0);
    check("t5_flush_full", 32'(bus2.full), 0);
    check("t5_flush_err", 32'(bus2.retire_err), 0);
    d2(1, 0, f_beq(5'd4, 5'd3), 1, 1, 0, 5'd0, 0);
    #1 check("t5_old_rd_free", 32'(bus2.stall), 0);
    @(negedge clk);
    check("t5_err_after", 32'(bus2.retire_err), 0);

    // 6: protocol violations
    d2(1, 1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd9, 0);
    @(negedge clk);
    check("t6_wrong_sel_err", 32'(bus2.retire_err), 1);
    check("t6_wrong_sel_cnt", 32'(bus2.count), 0);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);
    @(negedge clk);
    check("t6_err_pulse", 32'(bus2.retire_err), 0);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd3, 0);
    @(negedge clk);
    check("t6_empty_retire_err", 32'(bus2.retire_err), 1);
    d2(1, 1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 1, f_addi(5'd4, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(1, 1, f_addi(5'd7, 5'd0), 1, 0, 0, 5'd0, 0);
    #1 check("t6_full_stall", 32'(bus2.stall), 1);
    @(negedge clk);
    check("t6_full_push_err", 32'(bus2.retire_err), 1);
    check("t6_full_push_drop", 32'(bus2.count), 2);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd3, 0);
    @(negedge clk);
    d2(0, 0, 32'd0, 0, 0, 1, 5'd4, 0);
    @(negedge clk);
    check("t6_drain_cnt", 32'(bus2.count), 0);
    check("t6_drain_err", 32'(bus2.retire_err), 0);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);

    // DEPTH=3: keep two entries in flight through 10 push/pop pairs (pointer wrap)
    d3(1, 1, f_addi(5'd1, 5'd0), 0, 0, 0, 5'd0, 0);
    @(negedge clk);
    d3(1, 1, f_addi(5'd2, 5'd0), 0, 0, 0, 5'd0, 0);
    for (int k = 2; k < 12; k++) begin
      @(negedge clk);
      check("w3_cnt", 32'(bus3.count), 2);
      check("w3_err", 32'(bus3.retire_err), 0);
      d3(1, 1, f_addi(5'(k + 1), 5'(k - 1)), 1, 0, 1, 5'(k - 1), 0);
      #1 check("w3_same_cycle_release", 32'(bus3.stall), 0);
    end
    @(negedge clk);
    check("w3_err_last", 32'(bus3.retire_err), 0);
    d3(1, 0, f_beq(5'd12, 5'd0), 1, 0, 1, 5'd11, 0);
    #1 check("w3_young_blocks", 32'(bus3.stall), 1);
    @(negedge clk);
    d3(1, 0, f_beq(5'd12, 5'd0), 1, 0, 1, 5'd12, 0);
    #1 check("w3_young_release", 32'(bus3.stall), 0);
    @(negedge clk);
    check("w3_final_cnt", 32'(bus3.count), 0);
    check("w3_final_err", 32'(bus3.retire_err), 0);
    d3(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);

    // Asynchronous reset mid-operation clears the scoreboard
    d2(1, 1, f_addi(5'd3, 5'd0), 1, 0, 0, 5'd0, 0);
    @(negedge clk);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);
    #2 rstz = 1'b0;
    #1 check("rst_mid_cnt", 32'(bus2.count), 0);
    @(negedge clk);
    rstz = 1'b1;
    d2(0, 0, 32'd0, 0, 0, 1, 5'd3, 0);
    @(negedge clk);
    check("rst_mid_no_outstanding", 32'(bus2.retire_err), 1);
    d2(0, 0, 32'd0, 0, 0, 0, 5'd0, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
